verin_pwm_gen: RTL and testbench

//  Avalon-MM slave PWM generator for the actuator (verin) drive stage.

---
 rtl/verin_pwm_gen.sv | 104 ++++++++++
 tb/tb_verin_pwm_gen.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/verin_pwm_gen.sv
// verin_pwm_gen: Avalon-MM PWM generator for the actuator H-bridge.
// The CPU writes period, duty and direction into staging registers. The
// active copy reloads only when the generator is idle or at a period
// boundary, so a period in progress is never cut short or stretched.
module verin_pwm_gen #(
   parameter int CNT_W = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic [1:0]  address,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        enable,
   output logic        pwm_out,
   output logic        sens_out
);

   logic [CNT_W-1:0] period_s, duty_s;
   logic [CNT_W-1:0] period_a, duty_a;
   logic [CNT_W-1:0] cnt;
   logic             sens_s, sens_a;
   logic             wr, at_wrap, period_zero, load;
   logic             unused_wdata;

   assign wr          = chipselect & ~write_n;
   assign period_zero = (period_a == '0);
   // A zero period never wraps, so it is treated as a permanent boundary.
   assign at_wrap     = enable & ~period_zero & (cnt == period_a - CNT_W'(1));
   assign load        = ~enable | period_zero | at_wrap;

   // Only the low CNT_W bits of a write are stored.
   assign unused_wdata = ^writedata;

   // Staging registers written by the CPU.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_s <= '0;
         duty_s   <= '0;
         sens_s   <= 1'b0;
      end else if (wr) begin
         case (address)
            2'd0:    period_s <= writedata[CNT_W-1:0];
            2'd1:    duty_s   <= writedata[CNT_W-1:0];
            2'd2:    sens_s   <= writedata[0];
            default: ;
         endcase
      end
   end

   // Active set: copies the pre-edge staging values on a load edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         period_a <= '0;
         duty_a   <= '0;
         sens_a   <= 1'b0;
      end else if (load) begin
         period_a <= period_s;
         duty_a   <= duty_s;
         sens_a   <= sens_s;
      end
   end

   // Period counter, held at zero while idle or with a zero period.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (~enable | period_zero | at_wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Registered outputs, one cycle behind the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         pwm_out  <= 1'b0;
         sens_out <= 1'b0;
      end else begin
         pwm_out  <= enable & ~period_zero & (cnt < duty_a);
         sens_out <= sens_a;
      end
   end

   // Zero-wait-state read mux.
   always_comb begin
      readdata = '0;
      case (address)
         2'd0: readdata[CNT_W-1:0] = period_s;
         2'd1: readdata[CNT_W-1:0] = duty_s;
         2'd2: readdata[0]         = sens_s;
         2'd3: begin
            readdata[0]           = enable;
            readdata[1]           = pwm_out;
            readdata[2]           = sens_out;
            readdata[16 +: CNT_W] = cnt;
         end
         default: readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_verin_pwm_gen.sv
// Bench for verin_pwm_gen: each scenario pushes the expected per-cycle
// {pwm_out, sens_out, cnt} into a scoreboard queue and pops it as the
// DUT runs, sampling on the falling edge.
module tb_verin_pwm_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect;
   logic [1:0]  address;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        enable;
   logic        pwm_out;
   logic        sens_out;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        pwm;
      logic        sens;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   verin_pwm_gen #(.CNT_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .chipselect (chipselect),
      .address    (address),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .enable     (enable),
      .pwm_out    (pwm_out),
      .sens_out   (sens_out)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Caller is at a falling edge; the write lands on the next rising edge.
   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 2'd3;
      writedata  = '0;
   endtask

   task automatic wait_cnt(input int v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (readdata[31:16] == v[15:0]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic push_one(input logic p, input logic s, input int c);
      exp_t x;
      x.pwm  = p;
      x.sens = s;
      x.cnt  = c[15:0];
      sb.push_back(x);
   endtask

   // Sample k of a steady run: cnt = k mod P, pwm reflects count k-1.
   task automatic push_run(input int p, input int d, input int k0, input int n, input logic s);
      for (int k = k0; k < k0 + n; k++)
         push_one(((k - 1) % p) < d, s, k % p);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      reset = 1'b1; enable = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      address = 2'd3; writedata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 4; a++) begin
         address = a[1:0];
         #1;
         rd = readdata;
         checks++;
         if (rd !== 32'd0) begin
            failures++;
            $display("FAIL reset_read addr=%0d got=%h exp=%h", a, rd, 32'd0);
         end
      end
      address = 2'd3;
      checks++;
      if (pwm_out !== 1'b0 || sens_out !== 1'b0) begin
         failures++;
         $display("FAIL reset_outputs got pwm=%b sens=%b exp pwm=0 sens=0", pwm_out, sens_out);
      end
   endtask

   task automatic test_basic();
      bus_write(2'd0, 32'd10);
      bus_write(2'd1, 32'hFFFF_0003);
      address = 2'd0; #1;
      checks++;
      if (readdata !== 32'd10) begin
         failures++;
         $display("FAIL period_readback got=%h exp=%h", readdata, 32'd10);
      end
      address = 2'd1; #1;
      checks++;
      if (readdata !== 32'd3) begin
         failures++;
         $display("FAIL duty_readback got=%h exp=%h", readdata, 32'd3);
      end
      address = 2'd3;
      @(negedge clk);
      enable = 1'b1;
      push_run(10, 3, 1, 30, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt || readdata[0] !== 1'b1) begin
            failures++;
            $display("FAIL basic got pwm=%b sens=%b cnt=%0d en=%b exp pwm=%b sens=%b cnt=%0d en=1",
                     pwm_out, sens_out, readdata[31:16], readdata[0], e.pwm, e.sens, e.cnt);
         end
      end
   endtask

   task automatic test_duty_change();
      bit ok;
      wait_cnt(4, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL duty_change_wait got=timeout exp=cnt4");
      end
      bus_write(2'd1, 32'd6);
      for (int c = 6; c < 10; c++) push_one(1'b0, 1'b0, c);
      push_one(1'b0, 1'b0, 0);
      push_run(10, 6, 1, 20, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt) begin
            failures++;
            $display("FAIL duty_change got pwm=%b sens=%b cnt=%0d exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], e.pwm, e.sens, e.cnt);
         end
      end
   endtask

   task automatic test_boundaries();
      bit ok;
      bus_write(2'd1, 32'd12);
      wait_cnt(0, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL full_duty_wait got=timeout exp=cnt0");
      end
      push_run(10, 12, 1, 20, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt) begin
            failures++;
            $display("FAIL full_duty got pwm=%b sens=%b cnt=%0d exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], e.pwm, e.sens, e.cnt);
         end
      end
      wait_cnt(3, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL zero_period_wait got=timeout exp=cnt3");
      end
      bus_write(2'd0, 32'd0);
      for (int c = 5; c < 10; c++) push_one(1'b1, 1'b0, c);
      push_one(1'b1, 1'b0, 0);
      for (int i = 0; i < 10; i++) push_one(1'b0, 1'b0, 0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt) begin
            failures++;
            $display("FAIL zero_period got pwm=%b sens=%b cnt=%0d exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], e.pwm, e.sens, e.cnt);
         end
      end
   endtask

   task automatic test_enable_drop();
      bit ok;
      bus_write(2'd1, 32'd3);
      bus_write(2'd0, 32'd10);
      wait_cnt(1, ok);
      checks++;
      if (!ok || pwm_out !== 1'b1) begin
         failures++;
         $display("FAIL drop_setup got found=%b pwm=%b exp found=1 pwm=1", ok, pwm_out);
      end
      enable = 1'b0;
      push_one(1'b0, 1'b0, 0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt) begin
            failures++;
            $display("FAIL enable_drop got pwm=%b sens=%b cnt=%0d exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], e.pwm, e.sens, e.cnt);
         end
      end
      bus_write(2'd2, 32'd1);
      address = 2'd2; #1;
      checks++;
      if (readdata !== 32'd1) begin
         failures++;
         $display("FAIL ctrl_readback got=%h exp=%h", readdata, 32'd1);
      end
      address = 2'd3;
      push_one(1'b0, 1'b0, 0);
      push_one(1'b0, 1'b1, 0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt || readdata[2] !== e.sens) begin
            failures++;
            $display("FAIL sens_update got pwm=%b sens=%b cnt=%0d st2=%b exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], readdata[2], e.pwm, e.sens, e.cnt);
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bus_write(2'd1, 32'd5);
      @(negedge clk);
      enable = 1'b1;
      wait_cnt(3, ok);
      checks++;
      if (!ok || sens_out !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_setup got found=%b sens=%b exp found=1 sens=1", ok, sens_out);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int a = 0; a < 3; a++) begin
         address = a[1:0];
         #1;
         checks++;
         if (readdata !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_staging addr=%0d got=%h exp=%h", a, readdata, 32'd0);
         end
      end
      address = 2'd3;
      push_one(1'b0, 1'b0, 0);
      for (int i = 0; i < 12; i++) push_one(1'b0, 1'b0, 0);
      checks++;
      if (pwm_out !== 1'b0 || sens_out !== 1'b0 || readdata[31:16] !== 16'd0) begin
         failures++;
         $display("FAIL reset_mid_outputs got pwm=%b sens=%b cnt=%0d exp pwm=0 sens=0 cnt=0",
                  pwm_out, sens_out, readdata[31:16]);
      end
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt) begin
            failures++;
            $display("FAIL post_reset_idle got pwm=%b sens=%b cnt=%0d exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], e.pwm, e.sens, e.cnt);
         end
      end
      bus_write(2'd0, 32'd10);
      bus_write(2'd1, 32'd5);
      wait_cnt(9, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL rewrite_wait got=timeout exp=cnt9");
      end
      push_one(1'b0, 1'b0, 0);
      push_run(10, 5, 1, 20, 1'b0);
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (pwm_out !== e.pwm || sens_out !== e.sens || readdata[31:16] !== e.cnt) begin
            failures++;
            $display("FAIL rewrite_run got pwm=%b sens=%b cnt=%0d exp pwm=%b sens=%b cnt=%0d",
                     pwm_out, sens_out, readdata[31:16], e.pwm, e.sens, e.cnt);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_duty_change();
      test_boundaries();
      test_enable_drop();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
